ppu_writer: RTL and testbench

PPU_WRITER -- requirements
Module: ppu_writer

---
 rtl/ppu_writer_if.sv | 17 +
 rtl/ppu_writer.sv | 107 ++++++++++
 tb/tb_ppu_writer.sv | 392 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ppu_writer_if.sv
// ppu_writer_if: host write-request handshake plus the PPU register bus.
// The PPU writer is the slave on the request side and drives the bus side.
interface ppu_writer_if;
  logic        req_valid;
  logic        req_ready;
  logic [11:0] req_addr;
  logic [31:0] req_data;
  logic        chipselect;
  logic        write;
  logic [11:0] address;
  logic [31:0] writedata;

  modport master (output req_valid, req_addr, req_data,
                  input  req_ready, chipselect, write, address, writedata);
  modport slave  (input  req_valid, req_addr, req_data,
                  output req_ready, chipselect, write, address, writedata);
endinterface

// File: rtl/ppu_writer.sv
// ppu_writer: queues host table writes and replays them onto the PPU bus,
// one write every two cycles (ISSUE with chipselect, then HOLD so the PPU's
// registered write stage sees stable address/data).
// Optional feature: define PPU_WRITER_VBLANK_GATE_EN to only issue while
// vcount is in rows 480..523; otherwise the window is always open.
module ppu_writer #(
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  ppu_writer_if.slave            bus,
  input  logic [9:0]             vcount,
  output logic [$clog2(DEPTH):0] level,
  output logic                   bad_addr
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, HOLD = 2'd2} state_t;

  state_t        r_state, w_next;
  logic [43:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0]   r_level;
  logic [11:0]   r_addr;
  logic [31:0]   r_data;
  logic          r_bad;
  logic          w_win, w_acc, w_bad, w_push, w_pop;

`ifdef PPU_WRITER_VBLANK_GATE_EN
  // Row 524 is left out so nothing lands on the PPU at field start.
  assign w_win = (vcount >= 10'd480) && (vcount <= 10'd523);
`else
  logic w_unused_vcount;
  assign w_unused_vcount = ^vcount;
  assign w_win = 1'b1;
`endif

  // Ready looks only at the registered level: no full-FIFO bypass.
  assign bus.req_ready = (r_level < FULL);
  assign w_acc         = bus.req_valid && bus.req_ready;
  assign w_bad         = w_acc && (bus.req_addr[11:10] == 2'b11);
  assign w_push        = w_acc && !w_bad;
  assign w_pop         = (r_state != ISSUE) && (w_next == ISSUE);

  assign bus.address   = r_addr;
  assign bus.writedata = r_data;
  assign level         = r_level;
  assign bad_addr      = r_bad;

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next state: a new write may start from IDLE or straight after HOLD
  always_comb begin
    w_next = IDLE;
    case (r_state)
      IDLE:    w_next = (r_level != '0 && w_win) ? ISSUE : IDLE;
      ISSUE:   w_next = HOLD;
      HOLD:    w_next = (r_level != '0 && w_win) ? ISSUE : IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Bus strobes decoded from state; address/data come from the pop register
  always_comb begin
    bus.chipselect = (r_state == ISSUE);
    bus.write      = (r_state != IDLE);
  end

  // FIFO storage, no reset needed since level gates every read
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= {bus.req_addr, bus.req_data};
  end

  // FIFO pointers and occupancy; pointers wrap naturally at AW bits
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  // Captured bus address/data and the bad-address pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr <= '0;
      r_data <= '0;
      r_bad  <= 1'b0;
    end else begin
      if (w_pop) {r_addr, r_data} <= r_mem[r_rptr];
      r_bad <= w_bad;
    end
  end
endmodule

// File: tb/tb_ppu_writer.sv
// tb_ppu_writer: directed scenarios plus a random run, each compared cycle by
// cycle against a queue-based model of the writer.
module tb_ppu_writer;
  localparam int DEPTH = 8;
  localparam int LW    = $clog2(DEPTH) + 1;
  localparam int VW    = 48 + LW;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [9:0]    vcount = '0;
  logic [LW-1:0] level;
  logic          bad_addr;
  int            errors = 0;
  int            checks = 0;

  ppu_writer_if bif();

  ppu_writer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .bus(bif), .vcount(vcount),
    .level(level), .bad_addr(bad_addr)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL timeout: simulation did not finish, got running want done");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  logic [43:0]   q[$];
  bit            m_cs, m_wr, m_bad, m_ready;
  logic [11:0]   m_addr;
  logic [31:0]   m_data;
  logic [LW-1:0] m_level;

  function automatic bit win(input logic [9:0] v);
`ifdef PPU_WRITER_VBLANK_GATE_EN
    return (v >= 480) && (v <= 523);
`else
    return 1'b1;
`endif
  endfunction

  // A write starts whenever entries wait, the window is open and the bus did
  // not start a write in the previous cycle; write stays up one extra cycle.
  always @(posedge clk) begin : model
    bit acc, pop, was_cs;
    logic [43:0] e;
    if (reset) begin
      q.delete();
      m_cs = 0; m_wr = 0; m_bad = 0; m_addr = '0; m_data = '0;
    end else begin
      acc    = bif.req_valid && (q.size() < DEPTH);
      pop    = (q.size() > 0) && win(vcount) && !m_cs;
      was_cs = m_cs;
      m_bad  = acc && (bif.req_addr[11:10] == 2'b11);
      if (pop) begin
        e = q.pop_front();
        m_addr = e[43:32];
        m_data = e[31:0];
      end
      m_cs = pop;
      m_wr = pop || was_cs;
      if (acc && !m_bad) q.push_back({bif.req_addr, bif.req_data});
    end
    m_level = LW'(q.size());
    m_ready = (q.size() < DEPTH);
  end

  wire [VW-1:0] obs_vec = {bif.chipselect, bif.write, bif.address, bif.writedata,
                           level, bad_addr, bif.req_ready};
  wire [VW-1:0] exp_vec = {m_cs, m_wr, m_addr, m_data, m_level, m_bad, m_ready};

  // ---------------- stimulus helpers (no checking) ----------------
  task automatic drive(input bit v, input logic [11:0] a, input logic [31:0] d);
    bif.req_valid = v;
    bif.req_addr  = a;
    bif.req_data  = d;
  endtask

  function automatic logic [11:0] rnd_addr();
    return {2'($urandom_range(0, 2)), 10'($urandom)};
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1;
    drive(0, '0, '0);
    vcount = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (obs_vec !== {1'b0, 1'b0, 12'h0, 32'h0, LW'(0), 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_state got=%h want=%h", obs_vec, {1'b0, 1'b0, 12'h0, 32'h0, LW'(0), 1'b0, 1'b1});
    end
    checks++;
    if (obs_vec !== exp_vec) begin
      errors++;
      $display("FAIL reset_model got=%h want=%h", obs_vec, exp_vec);
    end
    reset = 1'b0;
  endtask

`ifdef PPU_WRITER_VBLANK_GATE_EN
  task automatic test_window();
    vcount = 10'd100;
    drive(1, 12'h001, 32'hAABBCCDD);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k == 0) drive(0, '0, '0);
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++;
        $display("FAIL window_closed_model k=%0d got=%h want=%h", k, obs_vec, exp_vec);
      end
      checks++;
      if (bif.chipselect !== 1'b0) begin
        errors++;
        $display("FAIL window_closed_cs k=%0d got=%b want=0", k, bif.chipselect);
      end
    end
    vcount = 10'd480;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++;
        $display("FAIL window_open_model k=%0d got=%h want=%h", k, obs_vec, exp_vec);
      end
      checks++;
      if ({bif.chipselect, bif.write, bif.address, bif.writedata} !==
          {1'(k == 0), 1'(k < 2), 12'h001, 32'hAABBCCDD}) begin
        errors++;
        $display("FAIL window_open_bus k=%0d got cs=%b wr=%b a=%h d=%h want cs=%b wr=%b a=001 d=aabbccdd",
                 k, bif.chipselect, bif.write, bif.address, bif.writedata, k == 0, k < 2);
      end
    end
  endtask
`endif

  task automatic test_latency();
    logic [11:0] a;
    logic [31:0] d;
`ifdef PPU_WRITER_VBLANK_GATE_EN
    vcount = 10'd480;
`else
    vcount = 10'd200;
`endif
    a = rnd_addr();
    d = $urandom;
    drive(1, a, d);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 0) drive(0, '0, '0);
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++;
        $display("FAIL latency_model k=%0d got=%h want=%h", k, obs_vec, exp_vec);
      end
      checks++;
      if (bif.chipselect !== 1'(k == 1) || (k == 1 && bif.address !== a)) begin
        errors++;
        $display("FAIL latency_cs k=%0d got cs=%b a=%h want cs=%b a=%h", k, bif.chipselect, bif.address, k == 1, a);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [11:0] a [3];
    logic [31:0] d [3];
    int          j;
    vcount = 10'd480;
    for (int i = 0; i < 3; i++) begin
      a[i] = rnd_addr();
      d[i] = $urandom;
    end
    drive(1, a[0], d[0]);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k < 2) drive(1, a[k+1], d[k+1]);
      else       drive(0, '0, '0);
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++;
        $display("FAIL b2b_model k=%0d got=%h want=%h", k, obs_vec, exp_vec);
      end
      if (k == 1 || k == 3 || k == 5) begin
        j = (k - 1) / 2;
        checks++;
        if ({bif.chipselect, bif.address, bif.writedata} !== {1'b1, a[j], d[j]}) begin
          errors++;
          $display("FAIL b2b_issue k=%0d got cs=%b a=%h d=%h want cs=1 a=%h d=%h",
                   k, bif.chipselect, bif.address, bif.writedata, a[j], d[j]);
        end
      end else begin
        checks++;
        if (bif.chipselect !== 1'b0) begin
          errors++;
          $display("FAIL b2b_gap k=%0d got cs=%b want cs=0", k, bif.chipselect);
        end
      end
    end
    checks++;
    if (level !== LW'(0)) begin
      errors++;
      $display("FAIL b2b_level got=%0d want=0", level);
    end
  endtask

  task automatic test_full();
    bit hit;
    vcount = 10'd0;
    drive(1, rnd_addr(), $urandom);
    hit = 0;
    for (int k = 0; k < 4 * DEPTH + 8; k++) begin
      @(negedge clk);
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++;
        $display("FAIL full_fill_model k=%0d got=%h want=%h", k, obs_vec, exp_vec);
      end
      if (!bif.req_ready) begin
        hit = 1;
        break;
      end
      drive(1, rnd_addr(), $urandom);
    end
    checks++;
    if (!hit || level !== LW'(DEPTH) || bif.req_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_reached got level=%0d ready=%b want level=%0d ready=0", level, bif.req_ready, DEPTH);
    end
    vcount = 10'd480;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++;
        $display("FAIL full_release_model k=%0d got=%h want=%h", k, obs_vec, exp_vec);
      end
`ifdef PPU_WRITER_VBLANK_GATE_EN
      if (k == 0) begin
        checks++;
        if (bif.req_ready !== 1'b1 || level !== LW'(DEPTH - 1)) begin
          errors++;
          $display("FAIL full_release_ready got ready=%b level=%0d want ready=1 level=%0d", bif.req_ready, level, DEPTH - 1);
        end
      end
`endif
      if (bif.req_ready) drive(1, rnd_addr(), $urandom);
    end
    drive(0, '0, '0);
    hit = 0;
    for (int k = 0; k < 4 * DEPTH + 8; k++) begin
      @(negedge clk);
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++;
        $display("FAIL full_drain_model k=%0d got=%h want=%h", k, obs_vec, exp_vec);
      end
      if (level == 0 && !bif.write) begin
        hit = 1;
        break;
      end
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL full_drain got level=%0d write=%b want level=0 write=0", level, bif.write);
    end
  endtask

  task automatic test_bad_addr();
    vcount = 10'd480;
    drive(1, 12'hC05, $urandom);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 0) drive(0, '0, '0);
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++;
        $display("FAIL bad_model k=%0d got=%h want=%h", k, obs_vec, exp_vec);
      end
      checks++;
      if ({bad_addr, level, bif.chipselect, bif.write} !== {1'(k == 0), LW'(0), 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL bad_pulse k=%0d got bad=%b level=%0d cs=%b wr=%b want bad=%b level=0 cs=0 wr=0",
                 k, bad_addr, level, bif.chipselect, bif.write, k == 0);
      end
    end
  endtask

  task automatic test_reset_hold();
    bit hit;
    vcount = 10'd0;
    for (int k = 0; k < 5; k++) begin
      drive(1, rnd_addr(), $urandom);
      @(negedge clk);
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++;
        $display("FAIL rsthold_fill_model k=%0d got=%h want=%h", k, obs_vec, exp_vec);
      end
    end
    drive(0, '0, '0);
    vcount = 10'd480;
    hit = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++;
        $display("FAIL rsthold_wait_model k=%0d got=%h want=%h", k, obs_vec, exp_vec);
      end
      if (bif.write && !bif.chipselect) begin
        hit = 1;
        break;
      end
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL rsthold_reach got write=%b cs=%b want hold state", bif.write, bif.chipselect);
    end
`ifdef PPU_WRITER_VBLANK_GATE_EN
    checks++;
    if (level !== LW'(4)) begin
      errors++;
      $display("FAIL rsthold_queued got=%0d want=4", level);
    end
`endif
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if ({bif.write, bif.chipselect, level} !== {1'b0, 1'b0, LW'(0)}) begin
      errors++;
      $display("FAIL rsthold_after got wr=%b cs=%b level=%0d want wr=0 cs=0 level=0", bif.write, bif.chipselect, level);
    end
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      checks++;
      if (obs_vec !== exp_vec || bif.write !== 1'b0) begin
        errors++;
        $display("FAIL rsthold_quiet k=%0d got=%h want=%h", k, obs_vec, exp_vec);
      end
    end
  endtask

  task automatic test_random();
    logic [9:0] vl [10] = '{10'd0, 10'd100, 10'd479, 10'd480, 10'd481,
                            10'd500, 10'd523, 10'd524, 10'd525, 10'd700};
    int hold_v;
    logic [11:0] a;
    hold_v = 0;
    for (int k = 0; k < 500; k++) begin
      if (hold_v == 0) begin
        vcount = vl[$urandom_range(0, 9)];
        hold_v = $urandom_range(1, 8);
      end
      hold_v--;
      a = rnd_addr();
      if ($urandom_range(0, 7) == 0) a[11:10] = 2'b11;
      drive($urandom_range(0, 2) != 0, a, $urandom);
      @(negedge clk);
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++;
        $display("FAIL random_model k=%0d got=%h want=%h", k, obs_vec, exp_vec);
      end
    end
    drive(0, '0, '0);
  endtask

  initial begin
    test_reset();
`ifdef PPU_WRITER_VBLANK_GATE_EN
    test_window();
`endif
    test_latency();
    test_back_to_back();
    test_full();
    test_bad_addr();
    test_reset_hold();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
